// File: rtl/attn_score_seq.sv
// Sequencer for an attention-score engine: streams Q then K into the engine's
// write ports, kicks the compute FSM, then drains the T x T score matrix.
module attn_score_seq #(
  parameter int T      = 8,
  parameter int DMAX   = 1024,
  parameter int DATA_W = 32,
  localparam int TW    = (T > 1) ? $clog2(T) : 1,
  localparam int DW    = (DMAX > 1) ? $clog2(DMAX) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [15:0]         d_len,
  output logic                busy,
  output logic                done,
  output logic                err,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_last,
  output logic                fsm_start,
  input  logic                fsm_busy,
  input  logic                fsm_done,
  output logic                cpu_q_we,
  output logic [TW-1:0]       cpu_q_t,
  output logic [DW-1:0]       cpu_q_d,
  output logic [DATA_W-1:0]   cpu_q_wdata,
  output logic [DATA_W/8-1:0] cpu_q_wmask,
  output logic                cpu_k_we,
  output logic [31:0]         cpu_k_t,
  output logic [31:0]         cpu_k_d,
  output logic [DATA_W-1:0]   cpu_k_wdata,
  output logic                score_re,
  output logic [TW-1:0]       score_tq,
  output logic [TW-1:0]       score_tk,
  input  logic [DATA_W-1:0]   score_rdata,
  input  logic                score_rvalid
);

  typedef enum logic [2:0] {IDLE, LOAD_Q, LOAD_K, KICK, WAIT, DRAIN, FIN} state_t;

  state_t        state, state_n;
  logic [15:0]   d_len_r;
  logic [15:0]   d_cnt;
  logic [TW-1:0] t_cnt;
  logic          err_r;
  logic [TW-1:0] rd_tq, rd_tk;
  logic          rd_all, rd_pend, rd_last_pend;

  logic hs, len_bad, last_d, last_t, last_elem, xfer, rd_ret;
  logic unused_fsm_busy;

  assign unused_fsm_busy = fsm_busy;

  assign len_bad   = (d_len == 16'd0) || (32'(d_len) > 32'(DMAX));
  assign hs        = in_valid && in_ready;
  assign last_d    = (d_cnt == d_len_r - 16'd1);
  assign last_t    = (t_cnt == TW'(T - 1));
  assign last_elem = hs && last_d && last_t;
  assign xfer      = out_valid && out_ready;
  assign rd_ret    = score_rvalid && rd_pend;

  assign busy      = (state != IDLE);
  assign in_ready  = (state == LOAD_Q) || (state == LOAD_K);
  assign fsm_start = (state == KICK);
  assign done      = (state == FIN);
  assign err       = (state == FIN) && err_r;
  // A new read goes out only when nothing is in flight and the output slot is free.
  assign score_re  = (state == DRAIN) && !rd_pend && !out_valid && !rd_all;
  assign score_tq  = rd_tq;
  assign score_tk  = rd_tk;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = len_bad ? FIN : LOAD_Q;
      LOAD_Q:  if (last_elem) state_n = LOAD_K;
      LOAD_K:  if (last_elem) state_n = KICK;
      KICK:    state_n = WAIT;
      WAIT:    if (fsm_done) state_n = DRAIN;
      DRAIN:   if (xfer && out_last) state_n = FIN;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Load stage: element counters and the registered write ports (one cycle behind the handshake).
  always_ff @(posedge clk) begin
    if (rst) begin
      d_len_r     <= '0;
      d_cnt       <= '0;
      t_cnt       <= '0;
      err_r       <= 1'b0;
      cpu_q_we    <= 1'b0;
      cpu_q_t     <= '0;
      cpu_q_d     <= '0;
      cpu_q_wdata <= '0;
      cpu_q_wmask <= '0;
      cpu_k_we    <= 1'b0;
      cpu_k_t     <= '0;
      cpu_k_d     <= '0;
      cpu_k_wdata <= '0;
    end else begin
      if (state == IDLE && start) begin
        err_r <= len_bad;
        d_cnt <= '0;
        t_cnt <= '0;
        if (!len_bad) d_len_r <= d_len;
      end
      if (hs) begin
        if (last_d) begin
          d_cnt <= '0;
          t_cnt <= last_t ? '0 : t_cnt + 1'b1;
        end else begin
          d_cnt <= d_cnt + 16'd1;
        end
      end
      cpu_q_we <= hs && (state == LOAD_Q);
      cpu_k_we <= hs && (state == LOAD_K);
      if (hs && state == LOAD_Q) begin
        cpu_q_t     <= t_cnt;
        cpu_q_d     <= d_cnt[DW-1:0];
        cpu_q_wdata <= in_data;
        cpu_q_wmask <= '1;
      end
      if (hs && state == LOAD_K) begin
        cpu_k_t     <= 32'(t_cnt);
        cpu_k_d     <= 32'(d_cnt[DW-1:0]);
        cpu_k_wdata <= in_data;
      end
    end
  end

  // Drain stage: read index walk, single outstanding read, output holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_tq        <= '0;
      rd_tk        <= '0;
      rd_all       <= 1'b0;
      rd_pend      <= 1'b0;
      rd_last_pend <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_last     <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        rd_tq  <= '0;
        rd_tk  <= '0;
        rd_all <= 1'b0;
      end
      if (score_re) begin
        rd_pend      <= 1'b1;
        rd_last_pend <= (rd_tq == TW'(T - 1)) && (rd_tk == TW'(T - 1));
        if (rd_tk == TW'(T - 1)) begin
          rd_tk <= '0;
          if (rd_tq == TW'(T - 1)) rd_all <= 1'b1;
          else                     rd_tq  <= rd_tq + 1'b1;
        end else begin
          rd_tk <= rd_tk + 1'b1;
        end
      end
      // A return and a transfer cannot coincide: reads issue only into an empty slot.
      if (rd_ret) begin
        rd_pend   <= 1'b0;
        out_valid <= 1'b1;
        out_data  <= score_rdata;
        out_last  <= rd_last_pend;
      end else if (xfer) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_attn_score_seq.sv
// Bench for attn_score_seq: models the compute engine and score memory, keeps
// scoreboards for Q/K writes and scores, and runs a job table plus corner sequences.
module tb_attn_score_seq;
  localparam int T = 8, DMAX = 1024, DATA_W = 32, TW = 3, DW = 10;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [15:0] d_len = '0;
  logic busy, done, err;
  logic in_valid = 1'b0, in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic out_valid, out_ready, out_last;
  logic [DATA_W-1:0] out_data;
  logic fsm_start, fsm_busy, fsm_done;
  logic cpu_q_we, cpu_k_we;
  logic [TW-1:0] cpu_q_t;
  logic [DW-1:0] cpu_q_d;
  logic [DATA_W-1:0] cpu_q_wdata, cpu_k_wdata;
  logic [DATA_W/8-1:0] cpu_q_wmask;
  logic [31:0] cpu_k_t, cpu_k_d;
  logic score_re, score_rvalid;
  logic [TW-1:0] score_tq, score_tk;
  logic [DATA_W-1:0] score_rdata;

  always #5 clk = ~clk;

  attn_score_seq #(.T(T), .DMAX(DMAX), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start), .d_len(d_len),
    .busy(busy), .done(done), .err(err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .fsm_start(fsm_start), .fsm_busy(fsm_busy), .fsm_done(fsm_done),
    .cpu_q_we(cpu_q_we), .cpu_q_t(cpu_q_t), .cpu_q_d(cpu_q_d),
    .cpu_q_wdata(cpu_q_wdata), .cpu_q_wmask(cpu_q_wmask),
    .cpu_k_we(cpu_k_we), .cpu_k_t(cpu_k_t), .cpu_k_d(cpu_k_d), .cpu_k_wdata(cpu_k_wdata),
    .score_re(score_re), .score_tq(score_tq), .score_tk(score_tk),
    .score_rdata(score_rdata), .score_rvalid(score_rvalid)
  );

  typedef struct { int d_len; bit exp_err; bit gaps; bit bp; } job_t;
  typedef struct { logic [31:0] t; logic [31:0] d; logic [31:0] data; } wr_t;
  typedef struct { logic [31:0] data; bit last; } out_t;

  job_t jobs[6];
  wr_t  eq[$], ek[$];
  out_t eo[$];

  int errors = 0, checks = 0;
  int n_qwe = 0, n_kwe = 0, n_fsm = 0, n_out = 0, n_done = 0;
  int bq, bk, bf, bo, bd, start_cyc, done_cyc = 0, cyc = 0;
  bit last_err = 1'b0, bp_mode = 1'b0;
  logic [31:0] salt = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] score_of(input logic [31:0] s, input int tq, input int tk);
    return s ^ 32'((tq << 4) | tk);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Compute engine: answers fsm_start with fsm_done a few cycles later.
  initial begin
    fsm_busy = 1'b0;
    fsm_done = 1'b0;
    forever begin
      @(negedge clk);
      if (fsm_start) begin
        fsm_busy = 1'b1;
        repeat ($urandom_range(3, 6)) @(negedge clk);
        fsm_done = 1'b1;
        @(negedge clk);
        fsm_done = 1'b0;
        fsm_busy = 1'b0;
      end
    end
  end

  // Score memory: 1-3 cycle read latency, plus occasional spurious rvalid while idle.
  initial begin
    int cnt, ptq, ptk;
    cnt = 0; ptq = 0; ptk = 0;
    score_rvalid = 1'b0;
    score_rdata  = '0;
    forever begin
      @(negedge clk);
      score_rvalid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          score_rvalid = 1'b1;
          score_rdata  = score_of(salt, ptq, ptk);
        end
      end else if (!score_re && $urandom_range(0, 7) == 0) begin
        score_rvalid = 1'b1;
        score_rdata  = 32'hDEAD_BEEF;
      end
      if (score_re) begin
        ptq = int'(score_tq);
        ptk = int'(score_tk);
        cnt = $urandom_range(1, 3);
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached at cycle %0d, required finish before it", cyc);
    $fatal(1, "watchdog");
  end

  task automatic begin_job(input int dl, input bit exp_err);
    salt = $urandom;
    if (!exp_err)
      for (int tq = 0; tq < T; tq++)
        for (int tk = 0; tk < T; tk++)
          eo.push_back('{data: score_of(salt, tq, tk), last: (tq == T-1 && tk == T-1)});
    bq = n_qwe; bk = n_kwe; bf = n_fsm; bo = n_out; bd = n_done;
    start_cyc = cyc;
    d_len = 16'(dl);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic feed(input int dl, input bit gaps);
    for (int m = 0; m < 2; m++)
      for (int t = 0; t < T; t++)
        for (int d = 0; d < dl; d++) begin
          wr_t e;
          bit ok;
          int k;
          e.t = 32'(t); e.d = 32'(d); e.data = $urandom;
          if (m == 0) eq.push_back(e);
          else        ek.push_back(e);
          in_data = e.data;
          in_valid = 1'b1;
          ok = 1'b0; k = 0;
          while (!ok && k < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            k++;
          end
          if (!ok) begin
            check("in_ready_timeout", 64'(ok), 64'd1);
            in_valid = 1'b0;
            return;
          end
          if (gaps && $urandom_range(0, 1) == 1) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
    in_valid = 1'b0;
  endtask

  task automatic finish_job(input int dl, input bit exp_err);
    int k;
    k = 0;
    while (n_done == bd && k < 40000) begin
      @(negedge clk);
      k++;
    end
    check("done_count", 64'(n_done - bd), 64'd1);
    check("err_flag", 64'(last_err), 64'(exp_err));
    if (exp_err) check("err_latency_le2", 64'(done_cyc - start_cyc <= 2), 64'd1);
    check("q_write_count", 64'(n_qwe - bq), 64'(exp_err ? 0 : T*dl));
    check("k_write_count", 64'(n_kwe - bk), 64'(exp_err ? 0 : T*dl));
    check("fsm_start_count", 64'(n_fsm - bf), 64'(exp_err ? 0 : 1));
    check("output_count", 64'(n_out - bo), 64'(exp_err ? 0 : T*T));
    @(negedge clk);
    check("busy_after_job", 64'(busy), 64'd0);
    check("scoreboard_empty", 64'(eq.size() + ek.size() + eo.size()), 64'd0);
  endtask

  task automatic poke_start();
    int k;
    k = 0;
    while (n_kwe <= bk + 2 && k < 500) begin
      @(negedge clk);
      k++;
    end
    start = 1'b1; d_len = 16'd0;
    @(posedge clk);
    #1;
    start = 1'b0; d_len = 16'd4;
    while (n_fsm == bf && k < 1000) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    fork
      begin : monitor
        wr_t e;
        out_t o;
        bit hold;
        logic [63:0] held;
        hold = 1'b0; held = '0;
        forever begin
          @(negedge clk);
          if (cpu_q_we) begin
            n_qwe++;
            check("q_expected", 64'(eq.size() > 0), 64'd1);
            if (eq.size() > 0) begin
              e = eq.pop_front();
              check("q_write", 64'({cpu_q_t, cpu_q_d, cpu_q_wdata}),
                    64'({e.t[TW-1:0], e.d[DW-1:0], e.data}));
              check("q_mask", 64'(cpu_q_wmask), 64'hF);
            end
          end
          if (cpu_k_we) begin
            n_kwe++;
            check("k_expected", 64'(ek.size() > 0), 64'd1);
            if (ek.size() > 0) begin
              e = ek.pop_front();
              check("k_addr", {cpu_k_t, cpu_k_d}, {e.t, e.d});
              check("k_data", 64'(cpu_k_wdata), 64'(e.data));
            end
          end
          if (fsm_start) n_fsm++;
          if (done) begin
            n_done++;
            last_err = err;
            done_cyc = cyc;
          end
          if (hold && !rst) check("out_stable", 64'({out_valid, out_last, out_data}), held);
          hold = out_valid && !out_ready;
          held = 64'({out_valid, out_last, out_data});
          if (out_valid && out_ready) begin
            n_out++;
            check("out_expected", 64'(eo.size() > 0), 64'd1);
            if (eo.size() > 0) begin
              o = eo.pop_front();
              check("out_score", 64'({out_last, out_data}), 64'({o.last, o.data}));
            end
          end
        end
      end
    join_none

    jobs[0] = '{d_len: 4,    exp_err: 1'b0, gaps: 1'b0, bp: 1'b0};
    jobs[1] = '{d_len: 0,    exp_err: 1'b1, gaps: 1'b0, bp: 1'b0};
    jobs[2] = '{d_len: 1025, exp_err: 1'b1, gaps: 1'b0, bp: 1'b0};
    jobs[3] = '{d_len: 4,    exp_err: 1'b0, gaps: 1'b1, bp: 1'b1};
    jobs[4] = '{d_len: 1,    exp_err: 1'b0, gaps: 1'b1, bp: 1'b1};
    jobs[5] = '{d_len: 1024, exp_err: 1'b0, gaps: 1'b0, bp: 1'b0};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", 64'({busy, done, err, in_ready, out_valid, out_last,
                              fsm_start, cpu_q_we, cpu_k_we, score_re}), 64'd0);
    check("reset_q_addr", 64'({cpu_q_t, cpu_q_d, cpu_q_wmask, score_tq, score_tk}), 64'd0);
    check("reset_k_addr", {cpu_k_t, cpu_k_d}, 64'd0);
    check("reset_data", {cpu_q_wdata, cpu_k_wdata}, 64'd0);
    check("reset_out_data", 64'(out_data), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      bp_mode = jobs[i].bp;
      begin_job(jobs[i].d_len, jobs[i].exp_err);
      if (!jobs[i].exp_err) feed(jobs[i].d_len, jobs[i].gaps);
      finish_job(jobs[i].d_len, jobs[i].exp_err);
      bp_mode = 1'b0;
    end

    // start pulses during LOAD_K and WAIT must be ignored
    begin_job(4, 1'b0);
    fork
      feed(4, 1'b0);
      poke_start();
    join
    finish_job(4, 1'b0);

    // reset in DRAIN after 10 outputs, then a fresh job
    begin
      int k;
      bit seen;
      begin_job(4, 1'b0);
      feed(4, 1'b0);
      k = 0;
      while (n_out - bo < 10 && k < 3000) begin
        @(negedge clk);
        k++;
      end
      check("reached_10_outputs", 64'(n_out - bo >= 10), 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      eo.delete(); eq.delete(); ek.delete();
      seen = 1'b0;
      repeat (8) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      check("no_stale_output", 64'(seen), 64'd0);
      check("idle_after_reset", 64'(busy), 64'd0);
      begin_job(2, 1'b0);
      feed(2, 1'b0);
      finish_job(2, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
